// File: rtl/aes_encipher_pblock.sv
// Iterative AES-128/AES-256 encipher datapath with 1, 2 or 4 parallel S-box lanes.
// Round keys and byte substitution come from an external key memory and a shared S-box bank.
module aes_encipher_pblock #(
  parameter int SBOX_WORDS  = 4,
  parameter int SUPPORT_256 = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      next,
  input  logic                      keylen,
  input  logic                      abort,
  output logic [3:0]                round,
  input  logic [127:0]              round_key,
  output logic [32*SBOX_WORDS-1:0]  sboxw,
  input  logic [32*SBOX_WORDS-1:0]  new_sboxw,
  input  logic [127:0]              block,
  output logic [127:0]              new_block,
  output logic                      ready
);

  // S = number of S-box cycles needed to substitute the four state words
  localparam int         S             = (SBOX_WORDS > 0) ? (4 / SBOX_WORDS) : 1;
  localparam logic [1:0] LAST_WORD_CTR = 2'(S - 1);
  localparam logic [3:0] NR_128        = 4'd10;
  localparam logic [3:0] NR_256        = 4'd14;

  generate
    if (SBOX_WORDS != 1 && SBOX_WORDS != 2 && SBOX_WORDS != 4) begin : g_bad_lanes
      $error("aes_encipher_pblock: SBOX_WORDS must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    SBOX = 2'd2,
    MAIN = 2'd3
  } fsm_e;

  typedef enum logic [2:0] {
    UPD_NONE  = 3'd0,
    UPD_INIT  = 3'd1,
    UPD_SBOX  = 3'd2,
    UPD_MAIN  = 3'd3,
    UPD_FINAL = 3'd4
  } upd_e;

  fsm_e         fsm_q;
  fsm_e         fsm_d;
  upd_e         upd;
  logic [127:0] state_q;
  logic [127:0] state_d;
  logic [3:0]   round_q;
  logic [1:0]   sword_ctr;
  logic         ready_q;
  logic         keylen_reg;
  logic [3:0]   nr;
  logic         last_round;
  logic [1:0]   word_base;

  logic round_clr;
  logic round_inc;
  logic ctr_clr;
  logic ctr_inc;
  logic ready_set;
  logic ready_clr;
  logic keylen_ld;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = c;
    return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
            b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
            b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
            xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_column(s[127:96]), mix_column(s[95:64]),
            mix_column(s[63:32]),  mix_column(s[31:0])};
  endfunction

  // Column c, row r lives at byte 4*c+r counted from the MSB; row r rotates left by r.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [31:0] get_word(input logic [127:0] s, input logic [1:0] k);
    return s[127 - 32*int'(k) -: 32];
  endfunction

  function automatic logic [127:0] put_word(input logic [127:0] s, input logic [1:0] k,
                                            input logic [31:0] w);
    logic [127:0] res;
    res = s;
    res[127 - 32*int'(k) -: 32] = w;
    return res;
  endfunction

  assign nr         = keylen_reg ? NR_256 : NR_128;
  assign last_round = (round_q == nr);
  assign word_base  = 2'(sword_ctr * SBOX_WORDS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE: if (next && !abort) fsm_d = INIT;
      INIT: fsm_d = abort ? IDLE : SBOX;
      SBOX: begin
        if (abort)                            fsm_d = IDLE;
        else if (sword_ctr == LAST_WORD_CTR)  fsm_d = MAIN;
      end
      MAIN: begin
        if (abort || last_round) fsm_d = IDLE;
        else                     fsm_d = SBOX;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    upd       = UPD_NONE;
    round_clr = 1'b0;
    round_inc = 1'b0;
    ctr_clr   = 1'b0;
    ctr_inc   = 1'b0;
    ready_set = 1'b0;
    ready_clr = 1'b0;
    keylen_ld = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (next && !abort) begin
          round_clr = 1'b1;
          ready_clr = 1'b1;
          keylen_ld = 1'b1;
        end
      end
      INIT: begin
        if (abort) begin
          ready_set = 1'b1;
        end else begin
          upd       = UPD_INIT;
          round_inc = 1'b1;
          ctr_clr   = 1'b1;
        end
      end
      SBOX: begin
        if (abort) begin
          ready_set = 1'b1;
        end else begin
          upd     = UPD_SBOX;
          ctr_inc = 1'b1;
        end
      end
      MAIN: begin
        if (abort) begin
          ready_set = 1'b1;
        end else begin
          ctr_clr   = 1'b1;
          round_inc = 1'b1;
          if (last_round) begin
            upd       = UPD_FINAL;
            ready_set = 1'b1;
          end else begin
            upd = UPD_MAIN;
          end
        end
      end
      default: ;
    endcase
  end

  // Substituted words land back in their own slots on the same edge they are presented.
  always_comb begin
    state_d = state_q;
    case (upd)
      UPD_INIT:  state_d = block ^ round_key;
      UPD_SBOX: begin
        for (int i = 0; i < SBOX_WORDS; i++) begin
          state_d = put_word(state_d, word_base + 2'(i), new_sboxw[32*i +: 32]);
        end
      end
      UPD_MAIN:  state_d = mix_columns(shift_rows(state_q)) ^ round_key;
      UPD_FINAL: state_d = shift_rows(state_q) ^ round_key;
      default: ;
    endcase
  end

  always_comb begin
    sboxw = '0;
    if (fsm_q == SBOX) begin
      for (int i = 0; i < SBOX_WORDS; i++) begin
        sboxw[32*i +: 32] = get_word(state_q, word_base + 2'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= '0;
      round_q    <= '0;
      sword_ctr  <= '0;
      ready_q    <= 1'b1;
      keylen_reg <= 1'b0;
    end else begin
      if (upd != UPD_NONE) state_q <= state_d;

      if (round_clr)      round_q <= '0;
      else if (round_inc) round_q <= round_q + 4'd1;

      if (ctr_clr)        sword_ctr <= '0;
      else if (ctr_inc)   sword_ctr <= sword_ctr + 2'd1;

      if (ready_set)      ready_q <= 1'b1;
      else if (ready_clr) ready_q <= 1'b0;

      if (keylen_ld)      keylen_reg <= keylen & (SUPPORT_256 != 0);
    end
  end

  assign round     = round_q;
  assign new_block = state_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_aes_encipher_pblock.sv
// Bench for aes_encipher_pblock: three instances (1/2/4 S-box lanes) share stimulus and are
// checked against FIPS-197 vectors and a byte-level AES reference model.
module tb_aes_encipher_pblock;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         next;
  logic         keylen;
  logic         abort;
  logic [127:0] block;
  logic [2:0]   rdy;
  logic [3:0]   rnd [3];
  logic [127:0] nb  [3];
  logic [127:0] rk  [3];
  logic [31:0]  sw1, nsw1;
  logic [63:0]  sw2, nsw2;
  logic [127:0] sw4, nsw4;

  logic [7:0]   sbox_tab [256];
  logic [127:0] rk_tab   [16];

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] C1_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_encipher_pblock #(.SBOX_WORDS(1), .SUPPORT_256(1)) u_l1 (
    .clk(clk), .reset_n(reset_n), .next(next), .keylen(keylen), .abort(abort),
    .round(rnd[0]), .round_key(rk[0]), .sboxw(sw1), .new_sboxw(nsw1),
    .block(block), .new_block(nb[0]), .ready(rdy[0]));

  aes_encipher_pblock #(.SBOX_WORDS(2), .SUPPORT_256(1)) u_l2 (
    .clk(clk), .reset_n(reset_n), .next(next), .keylen(keylen), .abort(abort),
    .round(rnd[1]), .round_key(rk[1]), .sboxw(sw2), .new_sboxw(nsw2),
    .block(block), .new_block(nb[1]), .ready(rdy[1]));

  aes_encipher_pblock #(.SBOX_WORDS(4), .SUPPORT_256(1)) u_l4 (
    .clk(clk), .reset_n(reset_n), .next(next), .keylen(keylen), .abort(abort),
    .round(rnd[2]), .round_key(rk[2]), .sboxw(sw4), .new_sboxw(nsw4),
    .block(block), .new_block(nb[2]), .ready(rdy[2]));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // Key memory and S-box bank models
  assign rk[0] = rk_tab[rnd[0]];
  assign rk[1] = rk_tab[rnd[1]];
  assign rk[2] = rk_tab[rnd[2]];

  always_comb begin
    nsw1 = subw(sw1);
    nsw2 = {subw(sw2[63:32]), subw(sw2[31:0])};
    nsw4 = {subw(sw4[127:96]), subw(sw4[95:64]), subw(sw4[63:32]), subw(sw4[31:0])};
  end

  // S-box from the GF(2^8) multiplicative inverse followed by the affine transform
  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox_tab[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
                    {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [255:0] key, input logic kl);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nrr;
    nk  = kl ? 8 : 4;
    nrr = kl ? 14 : 10;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4*(nrr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk_tab[r] = (r <= nrr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  function automatic logic [127:0] ref_enc(input logic [127:0] pt, input int nrr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] out;
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rk_tab[0][127 - 8*i -: 8];
    for (int r = 1; r <= nrr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[4*c + row] = s[4*((c + row) % 4) + row];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          if (r < nrr)
            s[4*c + row] = gmul(8'h02, t[4*c + row]) ^ gmul(8'h03, t[4*c + (row + 1) % 4]) ^
                           t[4*c + (row + 2) % 4] ^ t[4*c + (row + 3) % 4];
          else
            s[4*c + row] = t[4*c + row];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_tab[r][127 - 8*i -: 8];
    end
    for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = s[i];
    return out;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts all three instances together; next_at/abort_at are the edge numbers (edge 1 samples
  // the start) at which an extra next or an abort is sampled, 0 = none.
  task automatic run_block(input string tag, input logic [255:0] key, input logic kl,
                           input logic [127:0] pt, input logic [127:0] exp_ct,
                           input int next_at, input int abort_at);
    int         lat [3];
    logic [2:0] fell;
    int         nrr, s, exp_lat;
    nrr = kl ? 14 : 10;
    expand_key(key, kl);
    @(negedge clk);
    block = pt; keylen = kl; abort = 1'b0; next = 1'b1;
    lat  = '{-1, -1, -1};
    fell = '0;
    for (int e = 1; e <= 120; e++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        if (lat[k] >= 0 && !rdy[k]) fell[k] = 1'b1;
        if (lat[k] < 0 && rdy[k]) lat[k] = e;
      end
      if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
      next   = (e + 1 == next_at);
      abort  = (e + 1 == abort_at);
      keylen = ~kl;
    end
    next = 1'b0; abort = 1'b0; keylen = kl;
    for (int k = 0; k < 3; k++) begin
      s       = 4 >> k;
      exp_lat = (abort_at != 0) ? abort_at : 2 + nrr*(s + 1);
      check($sformatf("%s latency lanes=%0d", tag, 1 << k), 128'(lat[k]), 128'(exp_lat));
      check($sformatf("%s stays_idle lanes=%0d", tag, 1 << k), 128'(fell[k]), 128'(0));
      if (abort_at == 0) begin
        check($sformatf("%s ciphertext lanes=%0d", tag, 1 << k), nb[k], exp_ct);
        check($sformatf("%s final_round lanes=%0d", tag, 1 << k), 128'(rnd[k]), 128'(nrr + 1));
      end
    end
    check($sformatf("%s sboxw_idle", tag), 128'(|{sw1, sw2, sw4}), 128'(0));
  endtask

  initial begin
    logic [255:0] key;
    logic [127:0] pt;
    logic         kl;
    reset_n = 1'b0; next = 1'b0; keylen = 1'b0; abort = 1'b0; block = '0;
    for (int r = 0; r < 16; r++) rk_tab[r] = '0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset ready %0d", k), 128'(rdy[k]), 128'(1));
      check($sformatf("reset round %0d", k), 128'(rnd[k]), 128'(0));
      check($sformatf("reset new_block %0d", k), nb[k], 128'h0);
    end
    check("reset sboxw", 128'(|{sw1, sw2, sw4}), 128'(0));
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_block("c1",           C1_KEY, 1'b0, PT, C1_CT, 0, 0);
    run_block("c3",           C3_KEY, 1'b1, PT, C3_CT, 0, 0);
    run_block("c1_next10",    C1_KEY, 1'b0, PT, C1_CT, 10, 0);
    run_block("c1_next22",    C1_KEY, 1'b0, PT, C1_CT, 22, 0);
    run_block("c1_abort",     C1_KEY, 1'b0, PT, C1_CT, 0, 21);
    run_block("c1_post_abrt", C1_KEY, 1'b0, PT, C1_CT, 0, 0);
    run_block("c3_abort",     C3_KEY, 1'b1, PT, C3_CT, 0, 21);
    run_block("c3_post_abrt", C3_KEY, 1'b1, PT, C3_CT, 0, 0);

    for (int n = 0; n < 6; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      kl  = 1'($urandom_range(0, 1));
      expand_key(key, kl);
      run_block($sformatf("rand%0d", n), key, kl, pt, ref_enc(pt, kl ? 14 : 10), 0, 0);
    end

    // Asynchronous reset in the middle of a round, with next held high during reset
    expand_key(C1_KEY, 1'b0);
    @(negedge clk); block = PT; keylen = 1'b0; next = 1'b1;
    @(negedge clk); next = 1'b0;
    repeat (12) @(negedge clk);
    #2 reset_n = 1'b0; next = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("midreset ready %0d", k), 128'(rdy[k]), 128'(1));
      check($sformatf("midreset round %0d", k), 128'(rnd[k]), 128'(0));
      check($sformatf("midreset new_block %0d", k), nb[k], 128'h0);
    end
    @(negedge clk); reset_n = 1'b1; next = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("no_spurious_start ready %0d", k), 128'(rdy[k]), 128'(1));
      check($sformatf("no_spurious_start round %0d", k), 128'(rnd[k]), 128'(0));
    end
    run_block("c1_post_reset", C1_KEY, 1'b0, PT, C1_CT, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
